// File: rtl/led_flow_pkg.sv
// Shared types and constants for the LED flow sequencer: FSM state encoding,
// SPEED rate-select codes and the default step period.
package led_flow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] SPEED_X1 = 2'd0;
  localparam logic [1:0] SPEED_X2 = 2'd1;
  localparam logic [1:0] SPEED_X4 = 2'd2;
  localparam logic [1:0] SPEED_X8 = 2'd3;

  localparam int unsigned DEFAULT_STEP_CYCLES = 32'd12_500_000;

  // Terminal prescaler count for a given base period and rate select.
  function automatic int unsigned step_limit(input int unsigned cycles,
                                             input logic [1:0]  speed);
    return (cycles >> speed) - 32'd1;
  endfunction

endpackage

// File: rtl/led_flow_sequencer_prescaler.sv
// Step prescaler: free-running counter with a live, SPEED-dependent terminal
// count. Compare is ">=" so shortening the period mid-count steps at once.
module led_step_prescaler
  import led_flow_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = DEFAULT_STEP_CYCLES
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       run,
  input  logic       clr,
  input  logic [1:0] shift,
  output logic       tick
);

  localparam int CNT_W = $clog2(STEP_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;

  assign limit = CNT_W'(step_limit(STEP_CYCLES, shift));
  assign tick  = run && (cnt >= limit);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_flow_sequencer.sv
// LED flow sequencer top: IDLE/RUN/PAUSE FSM, one-hot pattern register and,
// when LED_FLOW_PINGPONG_EN is defined, the internal bounce-direction latch.
module led_flow_sequencer
  import led_flow_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = DEFAULT_STEP_CYCLES,
  parameter int unsigned LED_W       = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIR,
  input  logic [1:0]       SPEED,
  output logic [LED_W-1:0] LED_out,
  output logic             STEP_tick,
  output logic [1:0]       STATE
);

  state_t           state;
  logic             run;
  logic             clr;
  logic             step;
  logic [LED_W-1:0] next_led;

  // A held EN in PAUSE counts on the resume edge, so pausing never adds cycles.
  assign run   = EN && (state != ST_IDLE);
  assign clr   = (state == ST_IDLE);
  assign STATE = state;

  led_step_prescaler #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_prescaler (
    .CLK   (CLK),
    .RST   (RST),
    .run   (run),
    .clr   (clr),
    .shift (SPEED),
    .tick  (step)
  );

`ifdef LED_FLOW_PINGPONG_EN
  logic dir_q;
  logic dir_nxt;
  logic unused_dir;

  assign unused_dir = DIR;

  // Turn around on reaching an end lane so no end lane is shown twice.
  always_comb begin
    dir_nxt = dir_q;
    if (!dir_q && LED_out[LED_W-1]) begin
      dir_nxt = 1'b1;
    end else if (dir_q && LED_out[0]) begin
      dir_nxt = 1'b0;
    end
    next_led = dir_nxt ? (LED_out >> 1) : (LED_out << 1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dir_q <= 1'b0;
    end else if (state == ST_IDLE) begin
      dir_q <= 1'b0;
    end else if (step) begin
      dir_q <= dir_nxt;
    end
  end
`else
  assign next_led = DIR ? {LED_out[0], LED_out[LED_W-1:1]}
                        : {LED_out[LED_W-2:0], LED_out[LED_W-1]};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      LED_out   <= '0;
      STEP_tick <= 1'b0;
    end else begin
      STEP_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          state   <= EN ? ST_RUN : ST_IDLE;
          LED_out <= EN ? LED_W'(1) : '0;
        end
        ST_RUN, ST_PAUSE: begin
          state <= EN ? ST_RUN : ST_PAUSE;
          if (step) begin
            LED_out   <= next_led;
            STEP_tick <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          LED_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_flow_sequencer.sv
// Bench for led_flow_sequencer (STEP_CYCLES = 8, LED_W = 4): cycle scoreboard
// plus directed step-timing, pause, speed, direction and async-reset checks.
module tb_led_flow_sequencer;
  import led_flow_pkg::*;

  localparam int STEP = 8;
  localparam int LW   = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN = 1'b0;
  logic          DIR = 1'b0;
  logic [1:0]    SPEED = SPEED_X1;
  logic [LW-1:0] LED_out;
  logic          STEP_tick;
  logic [1:0]    STATE;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  led_flow_sequencer #(
    .STEP_CYCLES (STEP),
    .LED_W       (LW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .DIR       (DIR),
    .SPEED     (SPEED),
    .LED_out   (LED_out),
    .STEP_tick (STEP_tick),
    .STATE     (STATE)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs pushed at every edge, popped on the next falling edge.
  logic [6:0]    sb_q[$];
  logic [6:0]    sb_e;
  state_t        m_st = ST_IDLE;
  logic [LW-1:0] m_led = '0;
  logic          m_tick = 1'b0;
  int            m_cnt = 0;
`ifdef LED_FLOW_PINGPONG_EN
  logic          m_dir = 1'b0;
`endif

  always @(posedge CLK) begin
    if (RST) begin
      m_st = ST_IDLE; m_led = '0; m_tick = 1'b0; m_cnt = 0;
`ifdef LED_FLOW_PINGPONG_EN
      m_dir = 1'b0;
`endif
    end else begin
      m_tick = 1'b0;
      if (m_st == ST_IDLE) begin
        m_cnt = 0;
        if (EN) begin
          m_st  = ST_RUN;
          m_led = 4'b0001;
        end
      end else if (!EN) begin
        m_st = ST_PAUSE;
      end else begin
        m_st = ST_RUN;
        if (m_cnt >= (STEP >> SPEED) - 1) begin
          m_cnt  = 0;
          m_tick = 1'b1;
`ifdef LED_FLOW_PINGPONG_EN
          if (!m_dir && m_led[3]) m_dir = 1'b1;
          else if (m_dir && m_led[0]) m_dir = 1'b0;
          m_led = m_dir ? (m_led >> 1) : (m_led << 1);
`else
          m_led = DIR ? {m_led[0], m_led[3:1]} : {m_led[2:0], m_led[3]};
`endif
        end else begin
          m_cnt++;
        end
      end
    end
    sb_q.push_back({m_led, m_tick, 2'(m_st)});
  end

  always @(negedge CLK) begin
    chk("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      chk("sb_led", 32'(LED_out), 32'(sb_e[6:3]));
      chk("sb_tick", 32'(STEP_tick), 32'(sb_e[2]));
      chk("sb_state", 32'(STATE), 32'(sb_e[1:0]));
    end
  end

  // Directed expectations: pattern after each step and cycles since the previous action.
  logic [LW-1:0] seq [15];
  int            gap [15] = '{8, 8, 8, 8, 5, 1, 1, 1, 8, 8, 5, 8, 8, 8, 8};
  int            k = 0;

  task automatic do_step();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!STEP_tick && n < 40);
    chk($sformatf("step%0d_seen", k), 32'(STEP_tick), 32'd1);
    chk($sformatf("step%0d_gap", k), 32'(n), 32'(gap[k]));
    chk($sformatf("step%0d_led", k), 32'(LED_out), 32'(seq[k]));
    k++;
  endtask

  initial begin
`ifdef LED_FLOW_PINGPONG_EN
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b0010};
`else
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
            4'b0010, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010};
`endif
    repeat (2) @(negedge CLK);
    chk("rst_led", 32'(LED_out), 32'd0);
    chk("rst_state", 32'(STATE), 32'(ST_IDLE));
    chk("rst_tick", 32'(STEP_tick), 32'd0);

    RST = 1'b0;
    EN  = 1'b1;
    @(negedge CLK);
    chk("load_led", 32'(LED_out), 32'b0001);
    chk("load_tick", 32'(STEP_tick), 32'd0);
    chk("load_state", 32'(STATE), 32'(ST_RUN));
    repeat (4) do_step();

    // Pause after three counts; the remaining five counts follow the resume.
    repeat (3) @(negedge CLK);
    EN = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      chk("pause_led", 32'(LED_out), 32'(seq[3]));
      chk("pause_tick", 32'(STEP_tick), 32'd0);
    end
    chk("pause_state", 32'(STATE), 32'(ST_PAUSE));
    EN = 1'b1;
    do_step();

    repeat (5) @(negedge CLK);
    SPEED = SPEED_X8;
    repeat (3) do_step();
    SPEED = SPEED_X1;
    repeat (2) do_step();

    repeat (3) @(negedge CLK);
    DIR = 1'b1;
    repeat (4) do_step();

    // Asynchronous reset between edges at pattern 0100.
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("async_led", 32'(LED_out), 32'd0);
    chk("async_state", 32'(STATE), 32'(ST_IDLE));
    chk("async_tick", 32'(STEP_tick), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    DIR = 1'b0;
    @(negedge CLK);
    chk("reload_led", 32'(LED_out), 32'b0001);
    chk("reload_state", 32'(STATE), 32'(ST_RUN));
    do_step();

    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
